// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline types for the hazard controller.
//   REG_ADDR_W     register-address width (16-entry regfile)
//   hazard_state_t FSM states of the hazard controller
//   stage_ctrl_t   stall/flush bundle driven into the pipeline registers
package cpu_pkg;
   localparam int REG_ADDR_W = 4;
   typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH, MEM_WAIT} hazard_state_t;
   typedef struct packed {
      logic stall_fetch;
      logic stall_decode;
      logic stall_execute;
      logic stall_memory;
      logic flush_decode;
      logic flush_execute;
   } stage_ctrl_t;
endpackage

// File: rtl/hazard_perf_counter.sv
// hazard_perf_counter: saturating 32-bit event counter.
//   clk      pipeline clock, rising edge
//   rst_n    asynchronous active-low reset, clears the count
//   i_en     count this cycle
//   o_count  current count, holds at 2^32-1
module hazard_perf_counter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_en,
   output logic [31:0] o_count
);
   logic [31:0] r_count;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_count <= '0;
      else if (i_en && r_count != '1) r_count <= r_count + 32'd1;
   end
   assign o_count = r_count;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for load-use, taken-branch and memory-wait hazards.
//   clk, rst_n                          clock (rising edge), asynchronous active-low reset
//   rs1_decode, rs2_decode              source registers of the decode instruction
//   rd_execute, mem_read_execute        destination / load flag of the execute instruction
//   branch_taken_execute                branch resolved taken in execute
//   mem_req_memory, mem_ready           data-memory access in memory stage / completes this cycle
//   stall_fetch..stall_memory           hold the corresponding pipeline registers
//   flush_decode, flush_execute         clear fetch/decode and decode/execute registers
//   busy                                FSM not in RUN
//   stall_cycles, flush_cycles          perf counters, only with HAZARD_PERF_CNT_EN defined
module pipeline_hazard_controller
   import cpu_pkg::*;
#(
   parameter int LOAD_STALL_CYC = 1,
   parameter int BRANCH_PENALTY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] rs1_decode,
   input  logic [REG_ADDR_W-1:0] rs2_decode,
   input  logic [REG_ADDR_W-1:0] rd_execute,
   input  logic                  mem_read_execute,
   input  logic                  branch_taken_execute,
   input  logic                  mem_req_memory,
   input  logic                  mem_ready,
   output logic                  stall_fetch,
   output logic                  stall_decode,
   output logic                  stall_execute,
   output logic                  stall_memory,
   output logic                  flush_decode,
   output logic                  flush_execute,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0]           stall_cycles,
   output logic [31:0]           flush_cycles,
`endif
   output logic                  busy
);
   if (LOAD_STALL_CYC < 1 || LOAD_STALL_CYC > 7 || BRANCH_PENALTY < 1 || BRANCH_PENALTY > 7) begin : g_bad_param
      $error("LOAD_STALL_CYC and BRANCH_PENALTY must be within 1..7");
   end

   localparam logic [2:0] LS_INIT = 3'(LOAD_STALL_CYC - 1);
   localparam logic [2:0] BP_INIT = 3'(BRANCH_PENALTY - 1);

   hazard_state_t r_state, r_ret_state;
   logic [2:0]    r_cnt;
   hazard_state_t w_cur, w_state_nxt, w_ret_nxt;
   logic [2:0]    w_cnt_nxt, w_cnt_dec;
   logic          w_mem_wait, w_load_use, w_branch;
   stage_ctrl_t   w_ctrl;

   assign w_mem_wait = mem_req_memory && !mem_ready;
   assign w_load_use = mem_read_execute && (rd_execute == rs1_decode || rd_execute == rs2_decode);

   always_comb begin
      // While waiting on memory the interrupted state is parked in r_ret_state;
      // on the completion cycle that state acts immediately.
      w_cur       = (r_state == MEM_WAIT) ? r_ret_state : r_state;
      w_branch    = branch_taken_execute && (w_cur == RUN || w_cur == LOAD_STALL);
      w_cnt_dec   = (r_cnt == 3'd0) ? 3'd0 : r_cnt - 3'd1;
      w_ctrl      = '0;
      w_state_nxt = w_cur;
      w_ret_nxt   = r_ret_state;
      w_cnt_nxt   = r_cnt;
      if (w_mem_wait) begin
         w_ctrl.stall_fetch   = 1'b1;
         w_ctrl.stall_decode  = 1'b1;
         w_ctrl.stall_execute = 1'b1;
         w_ctrl.stall_memory  = 1'b1;
         w_state_nxt          = MEM_WAIT;
         w_ret_nxt            = w_cur;
      end else if (w_branch) begin
         w_ctrl.flush_decode  = 1'b1;
         w_ctrl.flush_execute = 1'b1;
         w_cnt_nxt            = BP_INIT;
         w_state_nxt          = (BP_INIT == 3'd0) ? RUN : FLUSH;
      end else if (w_cur == FLUSH) begin
         w_ctrl.flush_decode  = 1'b1;
         w_cnt_nxt            = w_cnt_dec;
         w_state_nxt          = (w_cnt_dec == 3'd0) ? RUN : FLUSH;
      end else if (w_cur == LOAD_STALL || (w_cur == RUN && w_load_use)) begin
         w_ctrl.stall_fetch   = 1'b1;
         w_ctrl.stall_decode  = 1'b1;
         w_ctrl.flush_execute = 1'b1;
         w_cnt_nxt            = (w_cur == RUN) ? LS_INIT : w_cnt_dec;
         w_state_nxt          = (w_cnt_nxt == 3'd0) ? RUN : LOAD_STALL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_ret_state <= RUN;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ret_state <= w_ret_nxt;
         r_cnt       <= w_cnt_nxt;
      end
   end

   // Gating with rst_n keeps every output low while reset is held, whatever the inputs.
   assign stall_fetch   = rst_n & w_ctrl.stall_fetch;
   assign stall_decode  = rst_n & w_ctrl.stall_decode;
   assign stall_execute = rst_n & w_ctrl.stall_execute;
   assign stall_memory  = rst_n & w_ctrl.stall_memory;
   assign flush_decode  = rst_n & w_ctrl.flush_decode;
   assign flush_execute = rst_n & w_ctrl.flush_execute;
   assign busy          = r_state != RUN;

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_counter u_stall_cnt (.clk(clk), .rst_n(rst_n), .i_en(stall_fetch), .o_count(stall_cycles));
   hazard_perf_counter u_flush_cnt (.clk(clk), .rst_n(rst_n), .i_en(flush_decode), .o_count(flush_cycles));
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed scoreboard bench for pipeline_hazard_controller.
module tb_pipeline_hazard_controller;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] rs1_decode = '0, rs2_decode = '0, rd_execute = '0;
   logic       mem_read_execute = 1'b0, branch_taken_execute = 1'b0;
   logic       mem_req_memory = 1'b0, mem_ready = 1'b0;
   logic       stall_fetch, stall_decode, stall_execute, stall_memory;
   logic       flush_decode, flush_execute, busy;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_cycles;
`endif

   typedef struct {string tag; logic [6:0] v;} exp_t;
   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   always #5 clk = ~clk;

   pipeline_hazard_controller #(.LOAD_STALL_CYC(2), .BRANCH_PENALTY(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_decode(rs1_decode), .rs2_decode(rs2_decode), .rd_execute(rd_execute),
      .mem_read_execute(mem_read_execute), .branch_taken_execute(branch_taken_execute),
      .mem_req_memory(mem_req_memory), .mem_ready(mem_ready),
      .stall_fetch(stall_fetch), .stall_decode(stall_decode),
      .stall_execute(stall_execute), .stall_memory(stall_memory),
      .flush_decode(flush_decode), .flush_execute(flush_execute),
`ifdef HAZARD_PERF_CNT_EN
      .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
`endif
      .busy(busy)
   );

   // Observed vector: {stall_fetch, stall_decode, stall_execute, stall_memory, flush_decode, flush_execute, busy}
   task automatic compare();
      exp_t       x;
      logic [6:0] obs;
      obs = {stall_fetch, stall_decode, stall_execute, stall_memory, flush_decode, flush_execute, busy};
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty got=%b exp=<entry>", obs);
      end else begin
         x = sb.pop_front();
         assert (obs === x.v) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b", x.tag, obs, x.v);
         end
      end
   endtask

   // ctl = {mem_read_execute, branch_taken_execute, mem_req_memory, mem_ready}
   task automatic step(input string tag, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic [3:0] ctl, input logic [6:0] e);
      rs1_decode = rs1;
      rs2_decode = rs2;
      rd_execute = rd;
      {mem_read_execute, branch_taken_execute, mem_req_memory, mem_ready} = ctl;
      sb.push_back('{tag: tag, v: e});
      if (rst_n && e[6]) exp_stall++;
      if (rst_n && e[2]) exp_flush++;
      @(negedge clk);
      compare();
      @(posedge clk);
      #1;
   endtask

   initial begin
      step("reset",          4'd0, 4'd0, 4'd0, 4'b0000, 7'b0000000);
      rst_n = 1'b1;
      step("idle",           4'd0, 4'd0, 4'd0, 4'b0000, 7'b0000000);
      step("lu_rs2_c0",      4'd1, 4'd5, 4'd5, 4'b1000, 7'b1100010);
      step("lu_rs2_c1",      4'd0, 4'd0, 4'd0, 4'b0000, 7'b1100011);
      step("lu_rs2_done",    4'd0, 4'd0, 4'd0, 4'b0000, 7'b0000000);
      step("lu_rs1_c0",      4'd3, 4'd9, 4'd3, 4'b1000, 7'b1100010);
      step("lu_rs1_c1",      4'd3, 4'd9, 4'd3, 4'b1000, 7'b1100011);
      step("no_load",        4'd7, 4'd7, 4'd7, 4'b0000, 7'b0000000);
      step("no_match",       4'd1, 4'd2, 4'd3, 4'b1000, 7'b0000000);
      step("br_c0",          4'd0, 4'd0, 4'd0, 4'b0100, 7'b0000110);
      step("br_c1",          4'd0, 4'd0, 4'd0, 4'b0000, 7'b0000101);
      step("br_done",        4'd0, 4'd0, 4'd0, 4'b0000, 7'b0000000);
      step("br_lu_c0",       4'd0, 4'd5, 4'd5, 4'b1100, 7'b0000110);
      step("br_lu_c1",       4'd0, 4'd0, 4'd0, 4'b0000, 7'b0000101);
      step("br_lu_done",     4'd0, 4'd0, 4'd0, 4'b0000, 7'b0000000);
      step("mw_ls_c0",       4'd0, 4'd5, 4'd5, 4'b1000, 7'b1100010);
      step("mw_ls_w1",       4'd0, 4'd0, 4'd0, 4'b0010, 7'b1111001);
      step("mw_ls_w2",       4'd0, 4'd0, 4'd0, 4'b0010, 7'b1111001);
      step("mw_ls_w3",       4'd0, 4'd0, 4'd0, 4'b0010, 7'b1111001);
      step("mw_ls_resume",   4'd0, 4'd0, 4'd0, 4'b0011, 7'b1100011);
      step("mw_ls_done",     4'd0, 4'd0, 4'd0, 4'b0000, 7'b0000000);
      step("mem_ready_now",  4'd0, 4'd0, 4'd0, 4'b0011, 7'b0000000);
      step("mw_run_w1",      4'd0, 4'd0, 4'd0, 4'b0010, 7'b1111000);
      step("mw_run_w2",      4'd0, 4'd0, 4'd0, 4'b0010, 7'b1111001);
      step("mw_run_rdy",     4'd0, 4'd0, 4'd0, 4'b0011, 7'b0000001);
      step("mw_run_done",    4'd0, 4'd0, 4'd0, 4'b0000, 7'b0000000);
      step("mw_over_br",     4'd0, 4'd0, 4'd0, 4'b0110, 7'b1111000);
      step("br_after_mw",    4'd0, 4'd0, 4'd0, 4'b0111, 7'b0000111);
      step("br_after_mw_fl", 4'd0, 4'd0, 4'd0, 4'b0000, 7'b0000101);
      step("br_after_mw_dn", 4'd0, 4'd0, 4'd0, 4'b0000, 7'b0000000);
      step("ls_br_c0",       4'd5, 4'd0, 4'd5, 4'b1000, 7'b1100010);
      step("ls_br_c1",       4'd0, 4'd0, 4'd0, 4'b0100, 7'b0000111);
      step("ls_br_c2",       4'd0, 4'd0, 4'd0, 4'b0000, 7'b0000101);
      step("ls_br_done",     4'd0, 4'd0, 4'd0, 4'b0000, 7'b0000000);
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      assert (stall_cycles === 32'(exp_stall)) else begin
         errors++;
         $error("FAIL stall_cycles got=%0d exp=%0d", stall_cycles, exp_stall);
      end
      checks++;
      assert (flush_cycles === 32'(exp_flush)) else begin
         errors++;
         $error("FAIL flush_cycles got=%0d exp=%0d", flush_cycles, exp_flush);
      end
`endif
      step("rst_br_c0",      4'd0, 4'd0, 4'd0, 4'b0100, 7'b0000110);
      rst_n = 1'b0;
      exp_stall = 0;
      exp_flush = 0;
      step("rst_mid_flush",  4'd0, 4'd0, 4'd0, 4'b0100, 7'b0000000);
      rst_n = 1'b1;
      step("post_reset",     4'd0, 4'd0, 4'd0, 4'b0000, 7'b0000000);
      step("post_reset_br",  4'd0, 4'd0, 4'd0, 4'b0100, 7'b0000110);
      step("post_reset_fl",  4'd0, 4'd0, 4'd0, 4'b0000, 7'b0000101);
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      assert (flush_cycles === 32'(exp_flush)) else begin
         errors++;
         $error("FAIL flush_after_reset got=%0d exp=%0d", flush_cycles, exp_flush);
      end
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
